// File: rtl/cache_assoc_wb.sv
`default_nettype none
// ============================================================================
// Module   : cache_assoc_wb
// Purpose  : N-way set-associative, write-back / write-allocate data cache
//            sitting between a CPU load/store port and a line-wide memory
//            port. Replacement is FIFO (SWAP_POLICY=0) or LRU (SWAP_POLICY=1).
//            Optional build macro CACHE_STATS_EN adds saturating hit/miss
//            counters on ports hit_cnt / miss_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module cache_assoc_wb #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 6,
    parameter int WAY_CNT       = 4,
    parameter int SWAP_POLICY   = 0,
    localparam int MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN,
    localparam int LINE_SIZE    = 2 ** LINE_ADDR_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               addr,
    input  logic                      rd_req,
    input  logic                      wr_req,
    input  logic [31:0]               wr_data,
    output logic [31:0]               rd_data,
    output logic                      miss,
    output logic                      mem_rd_req,
    output logic                      mem_wr_req,
    output logic [MEM_ADDR_LEN-1:0]   mem_addr,
    output logic [32*LINE_SIZE-1:0]   mem_wr_line,
    input  logic [32*LINE_SIZE-1:0]   mem_rd_line,
    input  logic                      mem_gnt
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt
`endif
);

    localparam int C_SET_CNT = 2 ** SET_ADDR_LEN;
    localparam int C_WAY_W   = $clog2(WAY_CNT);
    localparam int C_TOP     = 2 + LINE_ADDR_LEN + SET_ADDR_LEN + TAG_ADDR_LEN;

    localparam logic [1:0] C_ST_IDLE        = 2'd0;
    localparam logic [1:0] C_ST_SWAP_OUT    = 2'd1;
    localparam logic [1:0] C_ST_SWAP_IN     = 2'd2;
    localparam logic [1:0] C_ST_SWAP_IN_OK  = 2'd3;

    logic [1:0]               r_state;
    logic [31:0]              r_data  [C_SET_CNT][WAY_CNT][LINE_SIZE];
    logic [TAG_ADDR_LEN-1:0]  r_tag   [C_SET_CNT][WAY_CNT];
    logic [WAY_CNT-1:0]       r_valid [C_SET_CNT];
    logic [WAY_CNT-1:0]       r_dirty [C_SET_CNT];
    logic [C_WAY_W-1:0]       r_age   [C_SET_CNT][WAY_CNT];
    logic [TAG_ADDR_LEN-1:0]  r_req_tag;
    logic [TAG_ADDR_LEN-1:0]  r_victim_tag;
    logic [SET_ADDR_LEN-1:0]  r_req_set;
    logic [C_WAY_W-1:0]       r_victim_way;
    logic [32*LINE_SIZE-1:0]  r_fill_line;

    logic [LINE_ADDR_LEN-1:0] w_word;
    logic [SET_ADDR_LEN-1:0]  w_set;
    logic [TAG_ADDR_LEN-1:0]  w_tag;
    logic                     w_unused_addr;
    logic                     w_req, w_idle, w_hit, w_found_inv, w_victim_dirty;
    logic [C_WAY_W-1:0]       w_hit_way, w_victim;
    logic                     w_rd_hit, w_wr_hit, w_miss_start, w_fill;
    logic                     w_age_en;
    logic [SET_ADDR_LEN-1:0]  w_age_set;
    logic [C_WAY_W-1:0]       w_age_way;

    assign w_word        = addr[2 +: LINE_ADDR_LEN];
    assign w_set         = addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign w_tag         = addr[2 + LINE_ADDR_LEN + SET_ADDR_LEN +: TAG_ADDR_LEN];
    assign w_unused_addr = ^{addr[31:C_TOP], addr[1:0]};

    assign w_req  = rd_req | wr_req;
    assign w_idle = (r_state == C_ST_IDLE);
    assign w_fill = (r_state == C_ST_SWAP_IN_OK);

    // Tag lookup across all ways of the addressed set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int i = 0; i < WAY_CNT; i++) begin
            if (r_valid[w_set][i] && (r_tag[w_set][i] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = C_WAY_W'(i);
            end
        end
    end

    // Victim choice: first empty way, otherwise the oldest way
    always_comb begin
        w_victim    = '0;
        w_found_inv = 1'b0;
        for (int i = 0; i < WAY_CNT; i++) begin
            if (!r_valid[w_set][i] && !w_found_inv) begin
                w_victim    = C_WAY_W'(i);
                w_found_inv = 1'b1;
            end
        end
        if (!w_found_inv) begin
            for (int i = 0; i < WAY_CNT; i++) begin
                if (r_age[w_set][i] == C_WAY_W'(WAY_CNT - 1)) begin
                    w_victim = C_WAY_W'(i);
                end
            end
        end
    end

    assign w_victim_dirty = r_valid[w_set][w_victim] & r_dirty[w_set][w_victim];

    // A read wins when both requests are raised together
    assign miss         = w_req & ~(w_hit & w_idle);
    assign w_rd_hit     = w_idle & w_hit & rd_req;
    assign w_wr_hit     = w_idle & w_hit & wr_req & ~rd_req;
    assign w_miss_start = w_idle & w_req & ~w_hit;

    // Ages move on every fill; on hits only when running LRU
    assign w_age_en  = w_fill | ((SWAP_POLICY != 0) & w_idle & w_req & w_hit);
    assign w_age_set = w_fill ? r_req_set    : w_set;
    assign w_age_way = w_fill ? r_victim_way : w_hit_way;

    // Controller, line status bits, ages and load data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= C_ST_IDLE;
            rd_data      <= '0;
            r_req_tag    <= '0;
            r_req_set    <= '0;
            r_victim_way <= '0;
            r_victim_tag <= '0;
            for (int s = 0; s < C_SET_CNT; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAY_CNT; w++) begin
                    r_age[s][w] <= C_WAY_W'(WAY_CNT - 1 - w);
                end
            end
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_miss_start) begin
                        r_req_tag    <= w_tag;
                        r_req_set    <= w_set;
                        r_victim_way <= w_victim;
                        r_victim_tag <= r_tag[w_set][w_victim];
                        r_state      <= w_victim_dirty ? C_ST_SWAP_OUT : C_ST_SWAP_IN;
                    end
                end
                C_ST_SWAP_OUT: begin
                    if (mem_gnt) r_state <= C_ST_SWAP_IN;
                end
                C_ST_SWAP_IN: begin
                    if (mem_gnt) r_state <= C_ST_SWAP_IN_OK;
                end
                C_ST_SWAP_IN_OK: begin
                    r_valid[r_req_set][r_victim_way] <= 1'b1;
                    r_dirty[r_req_set][r_victim_way] <= 1'b0;
                    r_state                          <= C_ST_IDLE;
                end
                default: r_state <= C_ST_IDLE;
            endcase

            if (w_rd_hit) rd_data <= r_data[w_set][w_hit_way][w_word];
            if (w_wr_hit) r_dirty[w_set][w_hit_way] <= 1'b1;

            if (w_age_en) begin
                for (int w = 0; w < WAY_CNT; w++) begin
                    if (C_WAY_W'(w) == w_age_way) begin
                        r_age[w_age_set][w] <= '0;
                    end else if (r_age[w_age_set][w] < r_age[w_age_set][w_age_way]) begin
                        r_age[w_age_set][w] <= r_age[w_age_set][w] + 1'b1;
                    end
                end
            end
        end
    end

    // Data and tag storage; not cleared by reset, refill abandoned on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((r_state == C_ST_SWAP_IN) && mem_gnt) r_fill_line <= mem_rd_line;
            if (w_fill) begin
                for (int k = 0; k < LINE_SIZE; k++) begin
                    r_data[r_req_set][r_victim_way][k] <= r_fill_line[32*k +: 32];
                end
                r_tag[r_req_set][r_victim_way] <= r_req_tag;
            end
            if (w_wr_hit) r_data[w_set][w_hit_way][w_word] <= wr_data;
        end
    end

    assign mem_rd_req = (r_state == C_ST_SWAP_IN);
    assign mem_wr_req = (r_state == C_ST_SWAP_OUT);

    // Memory address: refill uses the requested line, write-back the victim
    always_comb begin
        mem_addr = '0;
        if (r_state == C_ST_SWAP_IN)  mem_addr = {r_req_tag, r_req_set};
        if (r_state == C_ST_SWAP_OUT) mem_addr = {r_victim_tag, r_req_set};
    end

    // Victim line presented only while writing back
    always_comb begin
        mem_wr_line = '0;
        if (r_state == C_ST_SWAP_OUT) begin
            for (int k = 0; k < LINE_SIZE; k++) begin
                mem_wr_line[32*k +: 32] = r_data[r_req_set][r_victim_way][k];
            end
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating counters: one hit per hitting IDLE cycle, one miss per miss entry
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (w_idle && w_req && w_hit && (hit_cnt != 32'hFFFF_FFFF)) hit_cnt <= hit_cnt + 1'b1;
            if (w_miss_start && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
